// File: rtl/audio_mixer_mc.sv
// N-channel signed-gain audio mixer, one MAC per cycle after each trigger.
// Saturating output with a single-cycle valid strobe and sticky overrun flag.
module audio_mixer_mc #(
    parameter int NUM_CH    = 4,
    parameter int WIDTH     = 16,
    parameter int GAIN_W    = 8,
    parameter int GAIN_FRAC = 6
) (
    input  logic                       audio_clk,
    input  logic                       rst_in,
    input  logic                       audio_trigger,
    input  logic [NUM_CH*WIDTH-1:0]    audio_in,
    input  logic [NUM_CH*GAIN_W-1:0]   gain_in,
    output logic [WIDTH-1:0]           audio_out,
    output logic                       audio_valid_out,
    output logic                       busy_out,
    output logic                       overrun_out
);

    localparam int PROD_W = WIDTH + GAIN_W;
    localparam int ACC_W  = PROD_W + $clog2(NUM_CH + 1);
    localparam int IDX_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int EXT_W  = ACC_W - PROD_W;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CH - 1);

    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_OUT   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]        out_q, out_d;
    logic                    valid_q, valid_d;
    logic                    ovr_q, ovr_d;
    logic                    snap_en;

    logic signed [WIDTH-1:0]  snap_a_q [NUM_CH];
    logic signed [GAIN_W-1:0] snap_g_q [NUM_CH];

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  shr;
    logic [WIDTH-1:0]         sat;

    assign prod     = snap_a_q[idx_q] * snap_g_q[idx_q];
    assign prod_ext = {{EXT_W{prod[PROD_W-1]}}, prod};

    // Arithmetic shift floors toward -inf, then clamp to the output range.
    assign shr = acc_q >>> GAIN_FRAC;

    always_comb begin
        sat = shr[WIDTH-1:0];
        if (shr > SAT_MAX) begin
            sat = SAT_MAX[WIDTH-1:0];
        end else if (shr < SAT_MIN) begin
            sat = SAT_MIN[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        out_d   = out_q;
        valid_d = 1'b0;
        ovr_d   = ovr_q;
        snap_en = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (audio_trigger) begin
                    snap_en = 1'b1;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_ACCUM;
                end
            end
            S_ACCUM: begin
                acc_d = acc_q + prod_ext;
                if (audio_trigger) begin
                    ovr_d = 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = S_OUT;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_OUT: begin
                out_d   = sat;
                valid_d = 1'b1;
                state_d = S_IDLE;
                if (audio_trigger) begin
                    ovr_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    // Snapshot needs no reset: it is always reloaded before being read.
    always_ff @(posedge audio_clk) begin
        if (snap_en && !rst_in) begin
            for (int k = 0; k < NUM_CH; k++) begin
                snap_a_q[k] <= audio_in[k*WIDTH +: WIDTH];
                snap_g_q[k] <= gain_in[k*GAIN_W +: GAIN_W];
            end
        end
    end

    assign audio_out       = out_q;
    assign audio_valid_out = valid_q;
    assign busy_out        = (state_q != S_IDLE);
    assign overrun_out     = ovr_q;

endmodule

// File: tb/tb_audio_mixer_mc.sv
// Directed bench for audio_mixer_mc with NUM_CH=4, WIDTH=16, GAIN_W=8.
// Expected results are hand-computed constants.
module tb_audio_mixer_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        trig = 1'b0;
    logic [63:0] ain = '0;
    logic [31:0] gin = '0;
    logic [15:0] aout;
    logic        valid;
    logic        busy;
    logic        ovr;

    int errors = 0;
    int checks = 0;

    audio_mixer_mc #(
        .NUM_CH(4), .WIDTH(16), .GAIN_W(8), .GAIN_FRAC(6)
    ) dut (
        .audio_clk(clk),
        .rst_in(rst),
        .audio_trigger(trig),
        .audio_in(ain),
        .gain_in(gin),
        .audio_out(aout),
        .audio_valid_out(valid),
        .busy_out(busy),
        .overrun_out(ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Trigger with (a,g); optionally swap inputs to (a2,g2) one cycle later.
    task automatic mix(input string tag, input logic [63:0] a,
                       input logic [31:0] g, input logic [63:0] a2,
                       input logic [31:0] g2, input logic signed [15:0] exp);
        int cnt;
        int at;
        logic [15:0] got;
        cnt = 0;
        at = 0;
        got = '0;
        ain = a;
        gin = g;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        ain = a2;
        gin = g2;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (valid) begin
                cnt++;
                if (cnt == 1) begin
                    at = c;
                    got = aout;
                end
            end
        end
        chk({tag, "_val"}, $signed(got), exp);
        chk({tag, "_cnt"}, cnt, 1);
        chk({tag, "_lat"}, at, 5);
    endtask

    localparam logic [63:0] A1 = {16'sd12345, 16'sd12345, 16'sd12345, 16'sd1000};
    localparam logic [31:0] G1 = {8'sd0, 8'sd0, 8'sd0, 8'sd64};

    initial begin
        #1;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_out", $signed(aout), 0);
        chk("rst_valid", valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovr", ovr, 0);

        mix("unity", A1, G1, A1, G1, 16'sd1000);

        mix("sat_pos", {4{16'sd20000}}, {4{8'sd64}},
            {4{16'sd20000}}, {4{8'sd64}}, 16'sd32767);
        mix("sat_neg", {4{-16'sd20000}}, {4{8'sd64}},
            {4{-16'sd20000}}, {4{8'sd64}}, -16'sd32768);

        mix("floor_neg", {48'd0, -16'sd3}, {24'd0, 8'sd32},
            {48'd0, -16'sd3}, {24'd0, 8'sd32}, -16'sd2);
        mix("floor_pos", {48'd0, 16'sd3}, {24'd0, 8'sd32},
            {48'd0, 16'sd3}, {24'd0, 8'sd32}, 16'sd1);

        mix("minmin_snap", {48'd0, -16'sd32768}, {24'd0, -8'sd128},
            {48'd0, 16'sd100}, {24'd0, 8'sd64}, 16'sd32767);

        mix("mixed", {-16'sd400, 16'sd50, 16'sd200, 16'sd100},
            {8'sd16, -8'sd64, 8'sd32, 8'sd64},
            {-16'sd400, 16'sd50, 16'sd200, 16'sd100},
            {8'sd16, -8'sd64, 8'sd32, 8'sd64}, 16'sd50);

        // Second trigger two cycles into a mix.
        ain = A1;
        gin = G1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        ain = '0;
        gin = '0;
        chk("ovr_busy", busy, 1);
        tick();
        chk("ovr_pre", ovr, 0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        chk("ovr_set", ovr, 1);
        tick();
        tick();
        chk("ovr_novalid", valid, 0);
        tick();
        chk("ovr_valid", valid, 1);
        chk("ovr_val", $signed(aout), 1000);
        tick();
        chk("ovr_single", valid, 0);
        chk("ovr_idle", busy, 0);
        tick();
        tick();
        chk("ovr_sticky", ovr, 1);

        // Reset three cycles into a mix aborts it.
        ain = A1;
        gin = G1;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_out", $signed(aout), 0);
        chk("abort_busy", busy, 0);
        chk("abort_ovr", ovr, 0);
        begin
            int seen;
            seen = 0;
            for (int c = 0; c < 8; c++) begin
                tick();
                if (valid) seen++;
            end
            chk("abort_novalid", seen, 0);
        end

        // Reset and trigger together: reset wins.
        rst = 1'b1;
        trig = 1'b1;
        tick();
        rst = 1'b0;
        trig = 1'b0;
        chk("rsttrig_busy", busy, 0);
        tick();
        chk("rsttrig_busy2", busy, 0);

        mix("after_rst", {-16'sd400, 16'sd50, 16'sd200, 16'sd100},
            {8'sd16, -8'sd64, 8'sd32, 8'sd64},
            {-16'sd400, 16'sd50, 16'sd200, 16'sd100},
            {8'sd16, -8'sd64, 8'sd32, 8'sd64}, 16'sd50);
        chk("after_rst_ovr", ovr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
